// File: rtl/rv32i_wbck_if.sv
// Write-back bus: ALU and LSU result streams in, register-file write port out.
// With RV32I_WBCK_SCOREBOARD_EN it also carries the load-issue / pending-vector signals.
interface rv32i_wbck_if #(
    parameter int WORD_WTH    = 32,
    parameter int REG_INX_WTH = 5
);
    logic                   alu_wbck_valid;
    logic                   alu_wbck_ready;
    logic                   alu_wbck_wen;
    logic [REG_INX_WTH-1:0] alu_wbck_idx;
    logic [WORD_WTH-1:0]    alu_wbck_dat;
    logic                   lsu_wbck_valid;
    logic                   lsu_wbck_ready;
    logic [REG_INX_WTH-1:0] lsu_wbck_idx;
    logic [WORD_WTH-1:0]    lsu_wbck_dat;
    logic                   wbck_dest_wen;
    logic [REG_INX_WTH-1:0] wbck_dest_idx;
    logic [WORD_WTH-1:0]    wbck_dest_dat;
    logic                   lbuf_empty;

`ifdef RV32I_WBCK_SCOREBOARD_EN
    logic                        lsu_issue_valid;
    logic [REG_INX_WTH-1:0]      lsu_issue_idx;
    logic [2**REG_INX_WTH-1:0]   lsu_pend_vec;

    modport master (
        output alu_wbck_valid, alu_wbck_wen, alu_wbck_idx, alu_wbck_dat,
        output lsu_wbck_valid, lsu_wbck_idx, lsu_wbck_dat,
        output lsu_issue_valid, lsu_issue_idx,
        input  alu_wbck_ready, lsu_wbck_ready,
        input  wbck_dest_wen, wbck_dest_idx, wbck_dest_dat, lbuf_empty,
        input  lsu_pend_vec
    );
    modport slave (
        input  alu_wbck_valid, alu_wbck_wen, alu_wbck_idx, alu_wbck_dat,
        input  lsu_wbck_valid, lsu_wbck_idx, lsu_wbck_dat,
        input  lsu_issue_valid, lsu_issue_idx,
        output alu_wbck_ready, lsu_wbck_ready,
        output wbck_dest_wen, wbck_dest_idx, wbck_dest_dat, lbuf_empty,
        output lsu_pend_vec
    );
`else
    modport master (
        output alu_wbck_valid, alu_wbck_wen, alu_wbck_idx, alu_wbck_dat,
        output lsu_wbck_valid, lsu_wbck_idx, lsu_wbck_dat,
        input  alu_wbck_ready, lsu_wbck_ready,
        input  wbck_dest_wen, wbck_dest_idx, wbck_dest_dat, lbuf_empty
    );
    modport slave (
        input  alu_wbck_valid, alu_wbck_wen, alu_wbck_idx, alu_wbck_dat,
        input  lsu_wbck_valid, lsu_wbck_idx, lsu_wbck_dat,
        output alu_wbck_ready, lsu_wbck_ready,
        output wbck_dest_wen, wbck_dest_idx, wbck_dest_dat, lbuf_empty
    );
`endif
endinterface

// File: rtl/rv32i_wbck.sv
// Write-back arbiter: merges ALU results and FIFO-buffered load results onto one register-file port.
// Optional RV32I_WBCK_SCOREBOARD_EN adds a registered per-register pending-load vector.
module rv32i_wbck #(
    parameter int WORD_WTH    = 32,
    parameter int REG_INX_WTH = 5,
    parameter int LBUF_DEPTH  = 2
) (
    input  logic         clk,
    input  logic         rst,
    rv32i_wbck_if.slave  wb
);
    localparam int PTR_W = $clog2(LBUF_DEPTH);

    typedef struct packed {
        logic [REG_INX_WTH-1:0] idx;
        logic [WORD_WTH-1:0]    dat;
    } wb_ent_t;

    wb_ent_t                lbuf_mem [LBUF_DEPTH];
    logic [PTR_W:0]         wptr;
    logic [PTR_W:0]         rptr;
    logic                   lbuf_full;
    logic                   lbuf_emp;
    logic                   push;
    logic                   pop;
    logic                   sel_lsu;
    logic                   sel_alu;
    logic                   sel_wen;
    wb_ent_t                lbuf_head;
    wb_ent_t                sel_ent;
    logic                   dest_wen;
    logic [REG_INX_WTH-1:0] dest_idx;
    logic [WORD_WTH-1:0]    dest_dat;

    // Extra MSB on each pointer separates full (wrap bits differ) from empty.
    assign lbuf_emp  = (wptr == rptr);
    assign lbuf_full = (wptr[PTR_W] != rptr[PTR_W]) &&
                       (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
    assign lbuf_head = lbuf_mem[rptr[PTR_W-1:0]];

    assign push    = wb.lsu_wbck_valid & ~lbuf_full;
    assign sel_lsu = ~lbuf_emp & (lbuf_full | ~wb.alu_wbck_valid);
    assign sel_alu = wb.alu_wbck_valid & ~sel_lsu;
    assign pop     = sel_lsu;

    assign wb.alu_wbck_ready = ~sel_lsu;
    assign wb.lsu_wbck_ready = ~lbuf_full;
    assign wb.lbuf_empty     = lbuf_emp;
    assign wb.wbck_dest_wen  = dest_wen;
    assign wb.wbck_dest_idx  = dest_idx;
    assign wb.wbck_dest_dat  = dest_dat;

    always_ff @(posedge clk) begin
        if (push) begin
            lbuf_mem[wptr[PTR_W-1:0]] <= '{idx: wb.lsu_wbck_idx, dat: wb.lsu_wbck_dat};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_comb begin
        sel_ent = lbuf_head;
        sel_wen = sel_lsu;
        if (sel_alu) begin
            sel_ent = '{idx: wb.alu_wbck_idx, dat: wb.alu_wbck_dat};
            sel_wen = wb.alu_wbck_wen;
        end
    end

    // x0 entries are still consumed; only the write strobe is suppressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dest_wen <= 1'b0;
            dest_idx <= '0;
            dest_dat <= '0;
        end else begin
            dest_wen <= sel_wen & (sel_ent.idx != '0);
            if (sel_alu | sel_lsu) begin
                dest_idx <= sel_ent.idx;
                dest_dat <= sel_ent.dat;
            end
        end
    end

`ifdef RV32I_WBCK_SCOREBOARD_EN
    localparam int NUM_REGS = 2**REG_INX_WTH;

    logic [NUM_REGS-1:0] pend_vec;
    logic [NUM_REGS-1:0] pend_nxt;

    // A new issue to the same rd as the retiring load must stay pending, so set is applied last.
    always_comb begin
        pend_nxt = pend_vec;
        if (pop) pend_nxt[lbuf_head.idx] = 1'b0;
        if (wb.lsu_issue_valid && (wb.lsu_issue_idx != '0)) pend_nxt[wb.lsu_issue_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend_vec <= '0;
        else     pend_vec <= pend_nxt;
    end

    assign wb.lsu_pend_vec = pend_vec;
`endif

endmodule

// File: tb/tb_rv32i_wbck.sv
// Bench for rv32i_wbck: per-cycle vector table for handshakes plus a timed write scoreboard,
// and hand-written sequences for the pending vector and mid-operation reset.
module tb_rv32i_wbck;
    logic clk;
    logic rst;

    rv32i_wbck_if #(.WORD_WTH(32), .REG_INX_WTH(5)) bus ();

    rv32i_wbck #(.WORD_WTH(32), .REG_INX_WTH(5), .LBUF_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        av;
        logic        aw;
        logic [4:0]  ai;
        logic [31:0] ad;
        int          ap;     // cycles until the ALU write shows, 0 = none expected
        logic        lv;
        logic [4:0]  li;
        logic [31:0] ld;
        int          lp;     // cycles until the load write shows, 0 = none expected
        logic        e_ar;
        logic        e_lr;
        logic        e_emp;
    } vec_t;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    exp_t aq[$];
    exp_t lq[$];
    int   cyc;
    int   n_chk;
    int   n_fail;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_wr(input string nm, input exp_t e);
        chk(nm, 64'({bus.wbck_dest_wen, bus.wbck_dest_idx, bus.wbck_dest_dat}),
                64'({1'b1, e.idx, e.dat}));
    endtask

    // Advance one clock and check the write port against whatever is due this cycle.
    task automatic tick();
        exp_t e;
        bit   hit;
        hit = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        if (aq.size() != 0 && aq[0].cyc == cyc) begin
            e = aq.pop_front();
            hit = 1'b1;
            chk_wr("alu_wr", e);
        end else if (lq.size() != 0 && lq[0].cyc == cyc) begin
            e = lq.pop_front();
            hit = 1'b1;
            chk_wr("lsu_wr", e);
        end
        if (!hit) chk("no_wr", 64'(bus.wbck_dest_wen), 64'(1'b0));
        while (aq.size() != 0 && aq[0].cyc < cyc) begin
            e = aq.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL missing_alu_wr: idx %0d never written, required at cycle %0d", e.idx, e.cyc);
        end
        while (lq.size() != 0 && lq[0].cyc < cyc) begin
            e = lq.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL missing_lsu_wr: idx %0d never written, required at cycle %0d", e.idx, e.cyc);
        end
    endtask

    task automatic idle_inputs();
        bus.alu_wbck_valid = 1'b0;
        bus.alu_wbck_wen   = 1'b0;
        bus.alu_wbck_idx   = '0;
        bus.alu_wbck_dat   = '0;
        bus.lsu_wbck_valid = 1'b0;
        bus.lsu_wbck_idx   = '0;
        bus.lsu_wbck_dat   = '0;
`ifdef RV32I_WBCK_SCOREBOARD_EN
        bus.lsu_issue_valid = 1'b0;
        bus.lsu_issue_idx   = '0;
`endif
    endtask

    vec_t tbl[20];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;

        tbl[0]  = '{1'b1,1'b1,5'd5, 32'h12345678,1, 1'b0,5'd0,32'h0,        0, 1'b1,1'b1,1'b1};
        tbl[1]  = '{1'b0,1'b0,5'd0, 32'h0,       0, 1'b0,5'd0,32'h0,        0, 1'b1,1'b1,1'b1};
        tbl[2]  = '{1'b0,1'b0,5'd0, 32'h0,       0, 1'b1,5'd7,32'hDEADBEEF, 2, 1'b1,1'b1,1'b1};
        tbl[3]  = '{1'b0,1'b0,5'd0, 32'h0,       0, 1'b0,5'd0,32'h0,        0, 1'b0,1'b1,1'b0};
        tbl[4]  = '{1'b0,1'b0,5'd0, 32'h0,       0, 1'b0,5'd0,32'h0,        0, 1'b1,1'b1,1'b1};
        tbl[5]  = '{1'b1,1'b1,5'd10,32'hA0A00010,1, 1'b1,5'd3,32'h33330003, 3, 1'b1,1'b1,1'b1};
        tbl[6]  = '{1'b1,1'b1,5'd11,32'hA0A00011,1, 1'b1,5'd4,32'h44440004, 4, 1'b1,1'b1,1'b0};
        tbl[7]  = '{1'b1,1'b1,5'd12,32'hA0A00012,0, 1'b0,5'd0,32'h0,        0, 1'b0,1'b0,1'b0};
        tbl[8]  = '{1'b1,1'b1,5'd12,32'hA0A00012,1, 1'b0,5'd0,32'h0,        0, 1'b1,1'b1,1'b0};
        tbl[9]  = '{1'b0,1'b0,5'd0, 32'h0,       0, 1'b0,5'd0,32'h0,        0, 1'b0,1'b1,1'b0};
        tbl[10] = '{1'b0,1'b0,5'd0, 32'h0,       0, 1'b0,5'd0,32'h0,        0, 1'b1,1'b1,1'b1};
        tbl[11] = '{1'b1,1'b1,5'd0, 32'hFFFFFFFF,0, 1'b1,5'd0,32'h0BAD0000, 0, 1'b1,1'b1,1'b1};
        tbl[12] = '{1'b0,1'b0,5'd0, 32'h0,       0, 1'b0,5'd0,32'h0,        0, 1'b0,1'b1,1'b0};
        tbl[13] = '{1'b0,1'b0,5'd0, 32'h0,       0, 1'b0,5'd0,32'h0,        0, 1'b1,1'b1,1'b1};
        tbl[14] = '{1'b1,1'b0,5'd6, 32'h66666666,0, 1'b0,5'd0,32'h0,        0, 1'b1,1'b1,1'b1};
        tbl[15] = '{1'b0,1'b0,5'd0, 32'h0,       0, 1'b0,5'd0,32'h0,        0, 1'b1,1'b1,1'b1};
        tbl[16] = '{1'b0,1'b0,5'd0, 32'h0,       0, 1'b1,5'd8,32'h88880008, 2, 1'b1,1'b1,1'b1};
        tbl[17] = '{1'b0,1'b0,5'd0, 32'h0,       0, 1'b1,5'd9,32'h99990009, 2, 1'b0,1'b1,1'b0};
        tbl[18] = '{1'b0,1'b0,5'd0, 32'h0,       0, 1'b0,5'd0,32'h0,        0, 1'b0,1'b1,1'b0};
        tbl[19] = '{1'b0,1'b0,5'd0, 32'h0,       0, 1'b0,5'd0,32'h0,        0, 1'b1,1'b1,1'b1};

        rst = 1'b1;
        idle_inputs();
        #3;
        chk("rst_empty",  64'(bus.lbuf_empty),     64'(1'b1));
        chk("rst_lsu_rdy",64'(bus.lsu_wbck_ready), 64'(1'b1));
        chk("rst_alu_rdy",64'(bus.alu_wbck_ready), 64'(1'b1));
        chk("rst_wr",     64'({bus.wbck_dest_wen, bus.wbck_dest_idx, bus.wbck_dest_dat}), 64'(0));
`ifdef RV32I_WBCK_SCOREBOARD_EN
        chk("rst_pend",   64'(bus.lsu_pend_vec), 64'(0));
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;

        for (int i = 0; i < 20; i++) begin
            bus.alu_wbck_valid = tbl[i].av;
            bus.alu_wbck_wen   = tbl[i].aw;
            bus.alu_wbck_idx   = tbl[i].ai;
            bus.alu_wbck_dat   = tbl[i].ad;
            bus.lsu_wbck_valid = tbl[i].lv;
            bus.lsu_wbck_idx   = tbl[i].li;
            bus.lsu_wbck_dat   = tbl[i].ld;
            #1;
            chk($sformatf("r%0d_alu_rdy", i), 64'(bus.alu_wbck_ready), 64'(tbl[i].e_ar));
            chk($sformatf("r%0d_lsu_rdy", i), 64'(bus.lsu_wbck_ready), 64'(tbl[i].e_lr));
            chk($sformatf("r%0d_empty", i),   64'(bus.lbuf_empty),     64'(tbl[i].e_emp));
            if (tbl[i].ap != 0) aq.push_back('{tbl[i].ai, tbl[i].ad, cyc + tbl[i].ap});
            if (tbl[i].lp != 0) lq.push_back('{tbl[i].li, tbl[i].ld, cyc + tbl[i].lp});
            tick();
        end
        idle_inputs();

`ifdef RV32I_WBCK_SCOREBOARD_EN
        bus.lsu_issue_valid = 1'b1;
        bus.lsu_issue_idx   = 5'd9;
        tick();
        bus.lsu_issue_valid = 1'b0;
        chk("pend_set", 64'(bus.lsu_pend_vec[9]), 64'(1'b1));
        bus.lsu_wbck_valid = 1'b1;
        bus.lsu_wbck_idx   = 5'd9;
        bus.lsu_wbck_dat   = 32'h09090909;
        lq.push_back('{5'd9, 32'h09090909, cyc + 2});
        tick();
        bus.lsu_wbck_valid = 1'b0;
        chk("pend_held", 64'(bus.lsu_pend_vec[9]), 64'(1'b1));
        tick();
        chk("pend_clr", 64'(bus.lsu_pend_vec), 64'(0));
        bus.lsu_issue_valid = 1'b1;
        tick();
        bus.lsu_issue_valid = 1'b0;
        bus.lsu_wbck_valid  = 1'b1;
        bus.lsu_wbck_dat    = 32'h19191919;
        lq.push_back('{5'd9, 32'h19191919, cyc + 2});
        tick();
        bus.lsu_wbck_valid  = 1'b0;
        bus.lsu_issue_valid = 1'b1;
        tick();
        bus.lsu_issue_valid = 1'b0;
        chk("pend_set_wins", 64'(bus.lsu_pend_vec), 64'(32'h0000_0200));
        idle_inputs();
        tick();
`endif

        // Fill the FIFO behind consume-only ALU traffic, then reset with both entries queued.
        bus.alu_wbck_valid = 1'b1;
        bus.alu_wbck_wen   = 1'b0;
        bus.alu_wbck_idx   = 5'd2;
        bus.alu_wbck_dat   = 32'hCAFE0001;
        bus.lsu_wbck_valid = 1'b1;
        bus.lsu_wbck_idx   = 5'd20;
        bus.lsu_wbck_dat   = 32'h20202020;
        tick();
        bus.lsu_wbck_idx   = 5'd21;
        bus.lsu_wbck_dat   = 32'h21212121;
        tick();
        idle_inputs();
        #1;
        chk("pre_rst_full", 64'({bus.lsu_wbck_ready, bus.lbuf_empty}), 64'(2'b00));
        rst = 1'b1;
        #1;
        chk("midrst_empty", 64'(bus.lbuf_empty),     64'(1'b1));
        chk("midrst_lsu_rdy",64'(bus.lsu_wbck_ready), 64'(1'b1));
        chk("midrst_wr",    64'({bus.wbck_dest_wen, bus.wbck_dest_idx, bus.wbck_dest_dat}), 64'(0));
`ifdef RV32I_WBCK_SCOREBOARD_EN
        chk("midrst_pend",  64'(bus.lsu_pend_vec), 64'(0));
`endif
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("post_rst%0d", k), 64'({bus.lbuf_empty, bus.alu_wbck_ready}), 64'(2'b11));
        end

        chk("sb_drained", 64'(aq.size() + lq.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rv32i_wbck.md
# rv32i_wbck

Write-back arbiter directly upstream of the integer register file. It merges the single-cycle ALU result stream and the long-latency LSU load-result stream into the register file's single write port (`wbck_dest_wen/idx/dat`). LSU results are buffered in a small FIFO. The block drives a registered write request one cycle after selection.

## Interface
Parameters:
- `WORD_WTH`, 32, data word width
- `REG_INX_WTH`, 5, register index width
- `LBUF_DEPTH`, 2, LSU result FIFO depth (power of two, ≥2)

Ports:
- `clk` in 1: the block's single clock.
- `rst` in 1: asynchronous, active-high reset.
- `alu_wbck_valid` in 1: ALU result valid.
- `alu_wbck_ready` out 1: ALU result accepted this cycle.
- `alu_wbck_wen` in 1: ALU instruction writes rd (0 = consume only).
- `alu_wbck_idx` in `REG_INX_WTH`: ALU rd.
- `alu_wbck_dat` in `WORD_WTH`: ALU result.
- `lsu_wbck_valid` in 1: load result valid.
- `lsu_wbck_ready` out 1: load result accepted (FIFO not full).
- `lsu_wbck_idx` in `REG_INX_WTH`: load rd.
- `lsu_wbck_dat` in `WORD_WTH`: load data.
- `wbck_dest_wen` out 1: register-file write enable (registered).
- `wbck_dest_idx` out `REG_INX_WTH`: write index (registered).
- `wbck_dest_dat` out `WORD_WTH`: write data (registered).
- `lbuf_empty` out 1: LSU FIFO empty, used by the flush/fence logic.

## Operation
- LSU FIFO:
  - Push when `lsu_wbck_valid & lsu_wbck_ready`.
  - `lsu_wbck_ready = ~full`, with no same-cycle pass-through when a pop frees a slot.
  - Pointers are `log2(LBUF_DEPTH)+1` bits; full/empty are decided by the MSB wrap bit.
- Selection, each cycle:
  - `sel_lsu = ~empty & (full | ~alu_wbck_valid)`.
  - `sel_alu = alu_wbck_valid & ~sel_lsu`.
  - `alu_wbck_ready = ~sel_lsu`. This is combinational; ALU ready does not depend on `alu_wbck_valid`.
- Pop FIFO head when `sel_lsu`.
- Output register loads on every cycle:
  - `wbck_dest_wen <= (sel_lsu | (sel_alu & alu_wbck_wen)) & (sel_idx != 0)`.
  - `wbck_dest_idx <= sel_idx`, `wbck_dest_dat <= sel_dat`.
  - When nothing is selected, wen=0 and idx/dat hold their previous values.
- x0 destination: the entry is consumed but wen is forced 0.
- ALU entries with `alu_wbck_wen=0` are consumed in one cycle and produce no write.
- LSU results are never dropped or reordered among themselves.

## Timing
- Reset (async, `rst=1`): FIFO pointers 0, `lbuf_empty=1`, `lsu_wbck_ready=1`, `wbck_dest_wen=0`, `wbck_dest_idx=0`, `wbck_dest_dat=0`.
- While the FIFO is empty after reset, `alu_wbck_ready=1`.
- ALU latency: accepted in cycle N → `wbck_dest_wen` high in N+1.
- LSU latency: accepted in N → in FIFO at N+1 → write visible in N+2 at the earliest.
- FIFO full with ALU valid: LSU wins and the ALU is stalled (`alu_wbck_ready=0`) for that cycle.
- Simultaneous push and pop on a non-full FIFO: both occur and the count is unchanged.
- Reset asserted mid-operation: FIFO contents are discarded and any pending write is cancelled immediately; no write is issued in the reset cycle.

## Configuration
- `RV32I_WBCK_SCOREBOARD_EN` defined: adds output `lsu_pend_vec` out `2**REG_INX_WTH` and inputs `lsu_issue_valid` in 1, `lsu_issue_idx` in `REG_INX_WTH`.
  - Set `lsu_pend_vec[idx]` on `lsu_issue_valid` when idx≠0.
  - Clear the bit for the FIFO head's idx on pop.
  - Set and clear of the same idx in the same cycle: set wins.
  - Reset value all-zero. The vector is registered and feeds the decode interlock.
- Macro undefined: these ports and the vector logic are absent; all other behaviour is identical.

## Test plan
- Reset then ALU valid, wen=1, idx=5, dat=0x12345678 in cycle 1 → `alu_wbck_ready=1`; cycle 2 `wbck_dest_wen=1`, idx=5, dat=0x12345678.
- LSU idx=7 dat=0xDEADBEEF with no ALU traffic → write idx 7 exactly 2 cycles after acceptance; `lbuf_empty` returns to 1.
- ALU valid every cycle while 2 loads (idx 3, 4) arrive → FIFO fills, `lsu_wbck_ready=0`. The next cycle `alu_wbck_ready=0` and idx 3 writes, then idx 4 writes, in order.
- ALU idx=0 dat=0xFFFFFFFF, and LSU idx=0 → both consumed, `wbck_dest_wen` stays 0.
- Scoreboard (macro on): issue idx 9 → `lsu_pend_vec[9]=1` next cycle. The load returns and writes → bit clears. Issue idx 9 again in the same cycle as the pop → bit stays 1.
- Assert `rst` with 2 entries in the FIFO → `lbuf_empty=1` immediately and no writes follow after reset is released.
